bcd_chain_counter: RTL and testbench

BCD_CHAIN_COUNTER -- requirements
Module: bcd_chain_counter

---
 rtl/bcd_chain_counter.sv | 155 +++++++++++++++
 tb/tb_bcd_chain_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_chain_counter.sv
// Cascaded digit counter with per-digit modulus (alternating even/odd bases),
// run/stop/halt control, lap capture and terminal-count carry pulse.
module bcd_chain_counter #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BASE_EVEN  = 10,
  parameter int unsigned BASE_ODD   = 6,
  parameter bit          WRAP       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    up,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] lap_value,
  output logic                    lap_valid,
  output logic                    carry,
  output logic                    running
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    StStopped = 2'd0,
    StRunning = 2'd1,
    StHalted  = 2'd2
  } state_e;

  // Largest legal value of digit idx (base - 1).
  function automatic logic [3:0] digit_max(input int unsigned idx);
    int unsigned b;
    b = ((idx % 2) == 0) ? BASE_EVEN : BASE_ODD;
    return 4'(b - 1);
  endfunction

  state_e         r_state;
  state_e         w_state_next;
  logic [W-1:0]   r_count;
  logic [W-1:0]   w_count_next;
  logic [W-1:0]   r_lap_value;
  logic           r_lap_valid;
  logic           r_carry;
  logic           r_running;

  logic [W-1:0]   w_step;
  logic [W-1:0]   w_load_val;
  logic           w_term_up;
  logic           w_term_dn;
  logic           w_terminal;
  logic           w_count_evt;
  logic           w_carry_evt;

  // Terminal detection on the pre-event count.
  always_comb begin
    w_term_up = 1'b1;
    w_term_dn = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_count[4*i +: 4] != digit_max(i)) w_term_up = 1'b0;
      if (r_count[4*i +: 4] != 4'd0)         w_term_dn = 1'b0;
    end
  end

  assign w_terminal  = up ? w_term_up : w_term_dn;
  assign w_count_evt = (r_state == StRunning) && enable && !clear && !load;
  assign w_carry_evt = w_count_evt && w_terminal;

  // Ripple step: a digit moves only when every lower digit is at its rollover value.
  always_comb begin
    logic       ripple;
    logic [3:0] dig;
    w_step = r_count;
    ripple = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = r_count[4*i +: 4];
      if (ripple) begin
        if (up) begin
          w_step[4*i +: 4] = (dig == digit_max(i)) ? 4'd0 : dig + 4'd1;
        end else begin
          w_step[4*i +: 4] = (dig == 4'd0) ? digit_max(i) : dig - 4'd1;
        end
      end
      ripple = ripple && (up ? (dig == digit_max(i)) : (dig == 4'd0));
    end
  end

  // Out-of-range preset digits are forced to zero.
  always_comb begin
    w_load_val = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i +: 4] <= digit_max(i)) begin
        w_load_val[4*i +: 4] = load_value[4*i +: 4];
      end
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (clear) begin
      w_count_next = '0;
    end else if (load) begin
      w_count_next = w_load_val;
    end else if (w_count_evt) begin
      if (!(w_terminal && !WRAP)) w_count_next = w_step;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StStopped: begin
        if (start_stop) w_state_next = StRunning;
      end
      StRunning: begin
        if (w_carry_evt && !WRAP) begin
          w_state_next = StHalted;
        end else if (start_stop) begin
          w_state_next = StStopped;
        end
      end
      StHalted: begin
        if (clear || load) w_state_next = StStopped;
      end
      default: w_state_next = StStopped;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StStopped;
      r_count     <= '0;
      r_lap_value <= '0;
      r_lap_valid <= 1'b0;
      r_carry     <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_lap_valid <= lap;
      r_carry     <= w_carry_evt;
      r_running   <= (w_state_next == StRunning);
      if (lap) r_lap_value <= r_count;
    end
  end

  assign count     = r_count;
  assign lap_value = r_lap_value;
  assign lap_valid = r_lap_valid;
  assign carry     = r_carry;
  assign running   = r_running;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed bench for bcd_chain_counter: a wrapping and a saturating instance share
// stimulus; expectations are queued per step and drained after each edge.
module tb_bcd_chain_counter;

  logic        clk = 1'b0;
  logic        rst, enable, up, start_stop, clear, load, lap;
  logic [15:0] load_value;
  logic [15:0] count_w, lap_value_w, count_s, lap_value_s;
  logic        lap_valid_w, carry_w, running_w;
  logic        lap_valid_s, carry_s, running_s;

  int checks   = 0;
  int failures = 0;

  typedef enum int {CntW, CarW, RunW, LapW, LvW, CntS, CarS, RunS, LapS, LvS} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];

  always #5 clk = ~clk;

  bcd_chain_counter #(.NUM_DIGITS(4), .BASE_EVEN(10), .BASE_ODD(6), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .start_stop(start_stop),
    .clear(clear), .load(load), .load_value(load_value), .lap(lap),
    .count(count_w), .lap_value(lap_value_w), .lap_valid(lap_valid_w),
    .carry(carry_w), .running(running_w)
  );

  bcd_chain_counter #(.NUM_DIGITS(4), .BASE_EVEN(10), .BASE_ODD(6), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .start_stop(start_stop),
    .clear(clear), .load(load), .load_value(load_value), .lap(lap),
    .count(count_s), .lap_value(lap_value_s), .lap_valid(lap_valid_s),
    .carry(carry_s), .running(running_s)
  );

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      CntW:    return {16'd0, count_w};
      CarW:    return {31'd0, carry_w};
      RunW:    return {31'd0, running_w};
      LapW:    return {16'd0, lap_value_w};
      LvW:     return {31'd0, lap_valid_w};
      CntS:    return {16'd0, count_s};
      CarS:    return {31'd0, carry_s};
      RunS:    return {31'd0, running_s};
      LapS:    return {16'd0, lap_value_s};
      default: return {31'd0, lap_valid_s};
    endcase
  endfunction

  task automatic exp_v(input string tag, input sel_e s, input logic [31:0] v);
    sb_item_t it;
    it.tag = tag;
    it.sel = s;
    it.exp = v;
    sb.push_back(it);
  endtask

  task automatic drain();
    sb_item_t    it;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.sel);
      checks++;
      assert (obs === it.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; up = 1'b1; start_stop = 1'b0;
    clear = 1'b0; load = 1'b0; lap = 1'b0; load_value = 16'h0;
    #1 rst = 1'b1;
    #2;
    exp_v("rst_cnt_w", CntW, 32'h0);  exp_v("rst_cnt_s", CntS, 32'h0);
    exp_v("rst_run_w", RunW, 32'h0);  exp_v("rst_car_w", CarW, 32'h0);
    exp_v("rst_lap_w", LapW, 32'h0);  exp_v("rst_lv_w", LvW, 32'h0);
    drain();
    #4 rst = 1'b0;

    // Illegal preset digits load as zero.
    load = 1'b1; load_value = 16'hA7C3;
    exp_v("load_a7c3_w", CntW, 32'h0703); exp_v("load_a7c3_s", CntS, 32'h0703);
    tick();

    load_value = 16'h5959;
    exp_v("load_5959", CntW, 32'h5959);
    tick();
    load = 1'b0; start_stop = 1'b1;
    exp_v("start_run_w", RunW, 32'h1); exp_v("start_run_s", RunS, 32'h1);
    exp_v("start_car_w", CarW, 32'h0);
    tick();

    // Up tick at terminal: wrap rolls over, saturate holds and halts.
    start_stop = 1'b0; enable = 1'b1; up = 1'b1;
    exp_v("wrap_up_cnt", CntW, 32'h0000); exp_v("wrap_up_car", CarW, 32'h1);
    exp_v("wrap_up_run", RunW, 32'h1);
    exp_v("sat_up_cnt", CntS, 32'h5959);  exp_v("sat_up_car", CarS, 32'h1);
    exp_v("sat_up_run", RunS, 32'h0);
    tick();
    enable = 1'b0;
    exp_v("car_drop_w", CarW, 32'h0); exp_v("car_drop_s", CarS, 32'h0);
    exp_v("hold_cnt_w", CntW, 32'h0000);
    tick();

    // Down tick at zero rolls to all base-1.
    enable = 1'b1; up = 1'b0;
    exp_v("wrap_dn_cnt", CntW, 32'h5959); exp_v("wrap_dn_car", CarW, 32'h1);
    exp_v("halt_cnt_s", CntS, 32'h5959);  exp_v("halt_run_s", RunS, 32'h0);
    tick();
    enable = 1'b0;
    exp_v("dn_car_drop", CarW, 32'h0);
    tick();

    // Saturating sequence from 0x5958.
    load = 1'b1; load_value = 16'h5958;
    exp_v("l5958_w", CntW, 32'h5958); exp_v("l5958_s", CntS, 32'h5958);
    exp_v("l5958_run_w", RunW, 32'h1); exp_v("l5958_run_s", RunS, 32'h0);
    tick();
    load = 1'b0; start_stop = 1'b1;
    exp_v("ss_run_w", RunW, 32'h0); exp_v("ss_run_s", RunS, 32'h1);
    tick();
    start_stop = 1'b0; enable = 1'b1; up = 1'b1;
    exp_v("sat_t1_cnt", CntS, 32'h5959); exp_v("sat_t1_car", CarS, 32'h0);
    exp_v("stopped_cnt_w", CntW, 32'h5958);
    tick();
    exp_v("sat_t2_cnt", CntS, 32'h5959); exp_v("sat_t2_car", CarS, 32'h1);
    exp_v("sat_t2_run", RunS, 32'h0);
    tick();
    exp_v("sat_t3_cnt", CntS, 32'h5959); exp_v("sat_t3_car", CarS, 32'h0);
    tick();
    enable = 1'b0; start_stop = 1'b1;
    exp_v("halt_ignore_ss", RunS, 32'h0); exp_v("ss_run_w2", RunW, 32'h1);
    tick();
    start_stop = 1'b0; clear = 1'b1;
    exp_v("clr_cnt_s", CntS, 32'h0); exp_v("clr_cnt_w", CntW, 32'h0);
    exp_v("clr_run_s", RunS, 32'h0); exp_v("clr_run_w", RunW, 32'h1);
    tick();
    clear = 1'b0; start_stop = 1'b1;
    exp_v("after_clr_ss_s", RunS, 32'h1); exp_v("after_clr_ss_w", RunW, 32'h0);
    tick();

    // Lap capture coincident with a count event.
    load = 1'b1; load_value = 16'h0129;
    exp_v("l0129", CntW, 32'h0129);
    exp_v("l0129_run_w", RunW, 32'h1); exp_v("l0129_run_s", RunS, 32'h0);
    tick();
    load = 1'b0; start_stop = 1'b0; lap = 1'b1; enable = 1'b1; up = 1'b1;
    exp_v("lap_cnt_w", CntW, 32'h0130); exp_v("lap_val_w", LapW, 32'h0129);
    exp_v("lap_vld_w", LvW, 32'h1);     exp_v("lap_cnt_s", CntS, 32'h0129);
    exp_v("lap_val_s", LapS, 32'h0129);
    tick();
    enable = 1'b0;
    exp_v("lap2_val_w", LapW, 32'h0130); exp_v("lap2_vld_w", LvW, 32'h1);
    tick();
    lap = 1'b0;
    exp_v("lap_vld_drop", LvW, 32'h0); exp_v("lap_hold_w", LapW, 32'h0130);
    tick();

    // Asynchronous reset between edges while running.
    load = 1'b1; load_value = 16'h0342;
    exp_v("l0342", CntW, 32'h0342);
    tick();
    load = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_v("arst_cnt", CntW, 32'h0); exp_v("arst_run", RunW, 32'h0);
    exp_v("arst_lap", LapW, 32'h0); exp_v("arst_lv", LvW, 32'h0);
    exp_v("arst_car", CarW, 32'h0); exp_v("arst_cnt_s", CntS, 32'h0);
    drain();
    #1 rst = 1'b0;

    start_stop = 1'b1;
    exp_v("post_rst_run", RunW, 32'h1); exp_v("post_rst_cnt", CntW, 32'h0);
    tick();
    start_stop = 1'b0; enable = 1'b1; up = 1'b1;
    exp_v("post_rst_up", CntW, 32'h0001); exp_v("post_rst_car", CarW, 32'h0);
    tick();
    up = 1'b0;
    exp_v("dir_change_dn", CntW, 32'h0000); exp_v("dir_change_car", CarW, 32'h0);
    tick();
    enable = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
